// File: rtl/usr_mem_pkg.sv
// Shared constants for the user memory arbiter and its parent: requester count,
// default SRAM geometry, macro tie-offs and the 2-way round-robin pick helper.
package usr_mem_pkg;

    localparam int NREQ       = 2;
    localparam int BDADDR_DEF = 10;
    localparam int BDWORD_DEF = 16;

    localparam logic [2:0] EMA_TIE      = 3'b010;
    localparam logic       COLLDISN_TIE = 1'b1;
    localparam logic       RET1N_TIE    = 1'b1;

    // Requester the pointer favours when both ask; a lone requester always wins.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] req, input logic ptr);
        logic [NREQ-1:0] pick;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = ptr ? 2'b10 : 2'b01;
            default: pick = 2'b00;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/usr_mem_arb_rr_arb2.sv
// Two-way round-robin arbiter with a per-requester grant mask and a 1-bit
// priority pointer that flips past the winner and holds when nothing is granted.
module rr_arb2
    import usr_mem_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    output logic [NREQ-1:0] cand,
    output logic [NREQ-1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    // Candidate selection, masked grant and next pointer.
    always_comb begin
        cand = rr_pick(req, ptr_q);
        if (rst) begin
            gnt = 2'b00;
        end else begin
            gnt = cand & ~mask;
        end
        if (|gnt) begin
            ptr_d = gnt[0];
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/usr_mem_arb.sv
// Arbitrates two requesters onto the read and write ports of a two-port SRAM
// macro owned by the parent; a read colliding with the same-cycle write waits.
module usr_mem_arb
    import usr_mem_pkg::*;
#(
    parameter int BDADDR = BDADDR_DEF,
    parameter int BDWORD = BDWORD_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        rd_req,
    input  logic [NREQ*BDADDR-1:0] rd_addr,
    output logic [NREQ-1:0]        rd_gnt,
    output logic [BDWORD-1:0]      rd_word,
    output logic [NREQ-1:0]        rd_vld,
    input  logic [NREQ-1:0]        wr_req,
    input  logic [NREQ*BDADDR-1:0] wr_addr,
    input  logic [NREQ*BDWORD-1:0] wr_word,
    output logic [NREQ-1:0]        wr_gnt,
    output logic                   mem_cena,
    output logic [BDADDR-1:0]      mem_aa,
    input  logic [BDWORD-1:0]      mem_qa,
    output logic                   mem_cenb,
    output logic [BDADDR-1:0]      mem_ab,
    output logic [BDWORD-1:0]      mem_db,
    output logic [BDWORD-1:0]      mem_wenb
);

    logic [NREQ-1:0]   rd_cand_s;
    logic [NREQ-1:0]   rd_mask_s;
    logic [NREQ-1:0]   wr_cand_s;
    logic [BDADDR-1:0] rd_cand_addr_s;
    logic              collide_s;
    logic [NREQ-1:0]   rd_vld_q;
    logic [NREQ-1:0]   rd_vld_d;

    rr_arb2 u_rd_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (rd_req),
        .mask (rd_mask_s),
        .cand (rd_cand_s),
        .gnt  (rd_gnt)
    );

    rr_arb2 u_wr_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (wr_req),
        .mask (2'b00),
        .cand (wr_cand_s),
        .gnt  (wr_gnt)
    );

    // Port muxing and collision detection; idle ports show requester-0 fields.
    always_comb begin
        if (rd_cand_s[1]) begin
            rd_cand_addr_s = rd_addr[BDADDR +: BDADDR];
        end else begin
            rd_cand_addr_s = rd_addr[0 +: BDADDR];
        end
        if (wr_cand_s[1]) begin
            mem_ab = wr_addr[BDADDR +: BDADDR];
            mem_db = wr_word[BDWORD +: BDWORD];
        end else begin
            mem_ab = wr_addr[0 +: BDADDR];
            mem_db = wr_word[0 +: BDWORD];
        end
        // Write commits on the coming edge, so a same-address read must wait a cycle.
        collide_s = (|wr_gnt) && (|rd_cand_s) && (rd_cand_addr_s == mem_ab);
        rd_mask_s = {NREQ{collide_s}};
        if (rd_gnt[1]) begin
            mem_aa = rd_addr[BDADDR +: BDADDR];
        end else begin
            mem_aa = rd_addr[0 +: BDADDR];
        end
        mem_cena = ~(|rd_gnt);
        mem_cenb = ~(|wr_gnt);
        mem_wenb = {BDWORD{mem_cenb}};
        rd_vld_d = rd_gnt;
    end

    // Read-valid tracks the grant one cycle later, matching macro latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q <= 2'b00;
        end else begin
            rd_vld_q <= rd_vld_d;
        end
    end

    assign rd_vld  = rd_vld_q;
    assign rd_word = mem_qa;

endmodule

// File: doc/usr_mem_arb.md
USR_MEM_ARB -- requirements
Module: usr_mem_arb

Interface
REQ-001 Parameter BDADDR, default 10: SRAM address width (RAMTP1024X16 geometry; 7 for RAMTP128X16).
REQ-002 Parameter BDWORD, default 16: SRAM word width.
REQ-003 clk  in  1: single clock, also drives both macro clocks CLKA/CLKB.
REQ-004 rst  in  1: asynchronous, active-high reset.
REQ-005 rd_req  in  2: per-requester read request, level.
REQ-006 rd_addr  in  2*BDADDR: packed read addresses, requester i at bits [i*BDADDR +: BDADDR].
REQ-007 rd_gnt  out  2: one-hot read grant, same cycle as request.
REQ-008 rd_word  out  BDWORD: read data, shared by both requesters.
REQ-009 rd_vld  out  2: one-hot, rd_word belongs to requester i.
REQ-010 wr_req  in  2: per-requester write request, level.
REQ-011 wr_addr  in  2*BDADDR; wr_word  in  2*BDWORD: packed write address and data, same packing as rd_addr.
REQ-012 wr_gnt  out  2: one-hot write grant, same cycle; the write commits on the next clk edge.
REQ-013 mem_cena  out  1 (active-low); mem_aa  out  BDADDR; mem_qa  in  BDWORD: macro read port.
REQ-014 mem_cenb  out  1 (active-low); mem_ab  out  BDADDR; mem_db  out  BDWORD; mem_wenb  out  BDWORD (active-low bit mask): macro write port.

Function
REQ-015 Read and write ports SHALL be arbitrated independently; each port grants at most one requester per cycle.
REQ-016 Each port SHALL keep a 1-bit round-robin priority pointer; on reset it points to requester 0.
REQ-017 Both requesting: grant the pointer's requester. One requesting: grant it regardless of the pointer.
REQ-018 After any grant to requester i, that port's pointer SHALL move to requester 1-i on the next edge; with no grant it holds.
REQ-019 Grants SHALL be combinational from req, address, and pointer; requesters hold req/addr/word stable until granted.
REQ-020 Write granted: mem_cenb=0, mem_ab/mem_db = granted requester's fields, mem_wenb all zeros; otherwise mem_cenb=1 and mem_wenb all ones.
REQ-021 Read granted: mem_cena=0, mem_aa = granted address; otherwise mem_cena=1.
REQ-022 Read latency SHALL be exactly 1 cycle: rd_vld[i]=1 on the cycle after rd_gnt[i], with rd_word=mem_qa; otherwise rd_vld=0.
REQ-023 rd_word SHALL pass mem_qa through combinationally and is valid only while rd_vld is nonzero.
REQ-024 Collision: if the read candidate's address equals the address of the write granted in the same cycle, the read SHALL NOT be granted, and the read pointer SHALL hold.
REQ-025 The stalled read is granted on a later cycle and returns the newly written data.
REQ-026 Back-to-back reads SHALL sustain one grant per cycle; rd_vld may stay high on consecutive cycles with alternating owners.
REQ-027 mem_aa/mem_ab/mem_db when idle: hold the requester-0 fields (no extra toggling logic).

Reset
REQ-028 While rst=1: rd_gnt=0, wr_gnt=0, mem_cena=1, mem_cenb=1, mem_wenb all ones, rd_vld=0, both pointers = 0.
REQ-029 All of these SHALL take effect asynchronously, including mid-read; a read granted in the cycle rst asserts produces no rd_vld.
REQ-030 The first grant SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-031 Package usr_mem_pkg SHALL hold the NREQ=2 constant, the default BDADDR/BDWORD values, and the EMA/COLLDISN/RET1N tie-off constants used by the parent.
REQ-032 One sub-module, rr_arb2 (2-way round-robin arbiter: req, mask, pointer, one-hot gnt), SHALL be instantiated once per port.
REQ-033 The macro instance SHALL stay in the parent; this block contains no storage array.

Verification
REQ-034 Write 0x1234 @5 via req0, then read @5 via req1 -> rd_vld=2'b10 one cycle after rd_gnt, rd_word=0x1234.
REQ-035 Both rd_req held for 4 cycles -> rd_gnt sequence 01,10,01,10; rd_vld follows it by 1 cycle.
REQ-036 Same cycle: write 0xBEEF @9 (req0) and read @9 (req1) -> wr_gnt=01, rd_gnt=00; next cycle rd_gnt=10, then rd_word=0xBEEF.
REQ-037 Same cycle: write @3 and read @4 -> both granted, mem_cena=0 and mem_cenb=0.
REQ-038 rst pulsed for half a cycle in the cycle after a read grant -> rd_vld=0 immediately, and the next grant goes to requester 0.
REQ-039 BDADDR=7: write and read the top address 127 -> correct data returned, with no address aliasing.
